// File: rtl/serial_add_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
package serial_add_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_cla8.sv
// 8-bit carry-lookahead slice with group generate/propagate and signed overflow.
module serial_add_cla8 import serial_add_pkg::*; (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               g,
    output logic               p,
    output logic               cout,
    output logic               ovf
);

    logic [SLICE_W-1:0] gen;
    logic [SLICE_W-1:0] prop;
    logic [SLICE_W:0]   c;

    always_comb begin
        gen  = a & b;
        prop = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            c[i+1] = gen[i] | (prop[i] & c[i]);
        end
        s = prop ^ c[SLICE_W-1:0];

        // Group terms are independent of cin so the caller can form the next carry itself.
        g = gen[0];
        for (int i = 1; i < SLICE_W; i++) begin
            g = gen[i] | (prop[i] & g);
        end
        p    = &prop;
        cout = c[SLICE_W];
        ovf  = c[SLICE_W] ^ c[SLICE_W-1];
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Byte-serial add/subtract sequencer time-sharing one CLA8 slice, LSB first.
// Optional SERIAL_ADD_EARLY_DONE_EN: finish early when the remaining bytes and carry are zero.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for ctrl_start; latches operands on accept
//   ST_RUN  | one byte per cycle through the slice, idx = byte index
//   ST_DONE | one-cycle completion; raises data_ready on the next edge
module serial_add_ctrl import serial_add_pkg::*; #(
    parameter  int NUM_SLICES = 4,
    localparam int W          = SLICE_W * NUM_SLICES
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ctrl_start,
    input  logic         ctrl_sub,
    input  logic [W-1:0] operand_A,
    input  logic [W-1:0] operand_B,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic         busy,
    output logic         data_ready
);

    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SLICES - 1);

    state_t             state_q, state_d;
    logic [W-1:0]       areg_q, areg_d;
    logic [W-1:0]       breg_q, breg_d;
    logic [W-1:0]       result_q, result_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               data_ready_q, data_ready_d;

    logic [SLICE_W-1:0] a_byte, b_byte, s_byte;
    logic               slice_g, slice_p, slice_cout, slice_ovf;
    logic               early_done;

    assign a_byte = areg_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign b_byte = breg_q[int'(idx_q)*SLICE_W +: SLICE_W];

    serial_add_cla8 u_cla8 (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .s    (s_byte),
        .g    (slice_g),
        .p    (slice_p),
        .cout (slice_cout),
        .ovf  (slice_ovf)
    );

`ifdef SERIAL_ADD_EARLY_DONE_EN
    always_comb begin
        early_done = ~carry_q;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (i >= int'(idx_q)) begin
                if ((areg_q[i*SLICE_W +: SLICE_W] != '0) || (breg_q[i*SLICE_W +: SLICE_W] != '0)) begin
                    early_done = 1'b0;
                end
            end
        end
    end
`else
    assign early_done = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        areg_d       = areg_q;
        breg_d       = breg_q;
        result_d     = result_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        carry_out_d  = carry_out_q;
        overflow_d   = overflow_q;
        busy_d       = 1'b0;
        data_ready_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_start) begin
                    areg_d   = operand_A;
                    breg_d   = operand_B ^ {W{ctrl_sub}};
                    carry_d  = ctrl_sub;
                    idx_d    = '0;
                    result_d = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (early_done) begin
                    for (int i = 0; i < NUM_SLICES; i++) begin
                        if (i >= int'(idx_q)) begin
                            result_d[i*SLICE_W +: SLICE_W] = '0;
                        end
                    end
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    result_d[int'(idx_q)*SLICE_W +: SLICE_W] = s_byte;
                    carry_d = slice_g | (slice_p & carry_q);
                    if (idx_q == IDX_LAST) begin
                        carry_out_d = slice_cout;
                        overflow_d  = slice_ovf;
                        state_d     = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                busy_d       = 1'b1;
                data_ready_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            areg_q       <= '0;
            breg_q       <= '0;
            result_q     <= '0;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            carry_out_q  <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            areg_q       <= areg_d;
            breg_q       <= breg_d;
            result_q     <= result_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            carry_out_q  <= carry_out_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign result     = result_q;
    assign carry_out  = carry_out_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;
    assign data_ready = data_ready_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (default 4 slices, 32-bit).
module tb_serial_add_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_start = 1'b0;
    logic        ctrl_sub = 1'b0;
    logic [31:0] operand_A = '0;
    logic [31:0] operand_B = '0;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;
    logic        busy;
    logic        data_ready;

    int errors = 0;
    int checks = 0;

`ifdef SERIAL_ADD_EARLY_DONE_EN
    localparam int SMALL_LAT = 3;
`else
    localparam int SMALL_LAT = 5;
`endif

    serial_add_ctrl #(.NUM_SLICES(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .ctrl_start (ctrl_start),
        .ctrl_sub   (ctrl_sub),
        .operand_A  (operand_A),
        .operand_B  (operand_B),
        .result     (result),
        .carry_out  (carry_out),
        .overflow   (overflow),
        .busy       (busy),
        .data_ready (data_ready)
    );

    always #5 clock = ~clock;

    // Called #1 after a rising edge; returns edges from the start edge to data_ready (-1 on timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output logic [31:0] res, output logic co, output logic ov, output int lat);
        operand_A  = a;
        operand_B  = b;
        ctrl_sub   = sub;
        ctrl_start = 1'b1;
        @(posedge clock); #1;
        ctrl_start = 1'b0;
        operand_A  = 32'hDEAD_BEEF;
        operand_B  = 32'h0BAD_F00D;
        ctrl_sub   = ~sub;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock); #1;
            if (data_ready) begin
                lat = n;
                break;
            end
        end
        res = result;
        co  = carry_out;
        ov  = overflow;
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic [31:0] exp_res, input logic exp_co,
                            input logic exp_ov, input int exp_lat);
        logic [31:0] res;
        logic        co, ov;
        int          lat;
        run_op(a, b, sub, res, co, ov, lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h, expected %h", name, res, exp_res);
        end
        checks++;
        if (co !== exp_co) begin
            errors++;
            $display("FAIL %s carry_out: got %b, expected %b", name, co, exp_co);
        end
        checks++;
        if (ov !== exp_ov) begin
            errors++;
            $display("FAIL %s overflow: got %b, expected %b", name, ov, exp_ov);
        end
        @(posedge clock); #1;
        checks++;
        if (data_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_end: data_ready=%b busy=%b, expected 0 0", name, data_ready, busy);
        end
        checks++;
        if (result !== exp_res) begin
            errors++;
            $display("FAIL %s result_hold: got %h, expected %h", name, result, exp_res);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({result, carry_out, overflow, busy, data_ready} !== 36'h0) begin
            errors++;
            $display("FAIL reset_state: got result=%h co=%b ov=%b busy=%b dr=%b, expected all 0",
                     result, carry_out, overflow, busy, data_ready);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_add();
        check_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 5);
        check_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 5);
    endtask

    task automatic test_sub();
        check_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 5);
        check_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 5);
    endtask

    task automatic test_small_add();
        check_op("small_add", 32'h0000_0012, 32'h0000_0034, 1'b0, 32'h0000_0046, 1'b0, 1'b0, SMALL_LAT);
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int first  = -1;
        logic [31:0] res_at_pulse = '0;
        operand_A  = 32'h1111_1111;
        operand_B  = 32'h2222_2222;
        ctrl_sub   = 1'b0;
        ctrl_start = 1'b1;
        @(posedge clock); #1;
        ctrl_start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b, expected 1", busy);
        end
        @(posedge clock); #1;
        operand_A  = 32'hFFFF_FFFF;
        operand_B  = 32'h0000_0001;
        ctrl_sub   = 1'b1;
        ctrl_start = 1'b1;
        @(posedge clock); #1;
        ctrl_start = 1'b0;
        for (int n = 3; n <= 14; n++) begin
            @(posedge clock); #1;
            if (data_ready) begin
                pulses++;
                if (first < 0) begin
                    first        = n;
                    res_at_pulse = result;
                end
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignored_start pulses: got %0d, expected 1", pulses);
        end
        checks++;
        if (first !== 5) begin
            errors++;
            $display("FAIL ignored_start latency: got %0d, expected 5", first);
        end
        checks++;
        if (res_at_pulse !== 32'h3333_3333) begin
            errors++;
            $display("FAIL ignored_start result: got %h, expected 33333333", res_at_pulse);
        end
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        operand_A  = 32'h0102_0304;
        operand_B  = 32'h1020_3040;
        ctrl_sub   = 1'b0;
        ctrl_start = 1'b1;
        @(posedge clock); #1;
        ctrl_start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({result, carry_out, overflow, busy, data_ready} !== 36'h0) begin
            errors++;
            $display("FAIL abort_state: got result=%h co=%b ov=%b busy=%b dr=%b, expected all 0",
                     result, carry_out, overflow, busy, data_ready);
        end
        reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clock); #1;
            if (data_ready || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d active cycles, expected 0", pulses);
        end
        check_op("after_abort", 32'h0102_0304, 32'h1020_3040, 1'b0, 32'h1122_3344, 1'b0, 1'b0, 5);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_small_add();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Multi-cycle sequencer that computes a full-width add or subtract by time-sharing one 8-bit carry-lookahead slice (CLA8), one byte per cycle, least-significant byte first.
- Carry is held in a register between slices.
- Sits beside the ALU as the area-reduced adder path used by multi-cycle ops. It uses a start/ready handshake like the multdiv unit.

Parameters:
- NUM_SLICES, 4, number of 8-bit slices; operand width W = 8*NUM_SLICES (32 by default).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ctrl_start  in  1  pulse; sampled only in IDLE.
- ctrl_sub  in  1  1 = A minus B, 0 = A plus B; sampled with ctrl_start.
- operand_A  in  W  first operand; sampled with ctrl_start.
- operand_B  in  W  second operand; sampled with ctrl_start.
- result  out  W  sum or difference; stable from data_ready until the next accepted start.
- carry_out  out  1  carry out of the top slice.
- overflow  out  1  signed overflow, taken from the top slice's OvF.
- busy  out  1  high from the cycle after an accepted start until data_ready drops.
- data_ready  out  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state = IDLE
  - result = 0, carry_out = 0, overflow = 0
  - busy = 0, data_ready = 0
  - slice index = 0, carry register = 0
- States: IDLE, RUN, DONE.
- IDLE:
  - On ctrl_start=1: latch A into areg and (B XOR {W{ctrl_sub}}) into breg.
  - Set carry register = ctrl_sub, idx = 0, clear result, then go to RUN.
  - On ctrl_start=0: stay in IDLE.
- RUN, each cycle:
  - Drive the slice with areg[idx], breg[idx] and the carry register.
  - Write slice S into result byte idx.
  - Carry register <= G | (P & Cin).
  - If idx == NUM_SLICES-1: carry_out <= slice carry, overflow <= slice OvF, go to DONE. Otherwise idx++.
- DONE: data_ready = 1 and busy = 1 for exactly one cycle, then go to IDLE.
- Latency:
  - ctrl_start sampled at edge k gives data_ready high in the cycle after edge k+NUM_SLICES+1.
  - Default: 5 edges after start.
  - Throughput is one operation per NUM_SLICES+2 cycles.
- ctrl_start while busy (RUN or DONE) is ignored, with no effect on in-flight state.
- Operand inputs may change freely after the start cycle; only latched copies are used.
- Reset asserted mid-operation aborts: no data_ready pulse and all outputs at reset values on the next cycle.
- Width rules:
  - Result is modulo 2^W.
  - carry_out for subtract is the no-borrow flag: 1 when A >= B, unsigned.
  - idx width is clog2(NUM_SLICES), minimum 1; it wraps to 0 only via IDLE.

Optional Feature:
- Macro SERIAL_ADD_EARLY_DONE_EN.
- Defined:
  - At the start of each RUN cycle, if the carry register = 0 and all not-yet-processed bytes of areg and breg (idx..NUM_SLICES-1) are zero, fill the remaining result bytes with 0.
  - Also set carry_out = 0, overflow = 0, and go straight to DONE.
  - Latency becomes variable (minimum 2 edges to data_ready).
- Undefined: fixed latency as above; no zero-detect logic is synthesized.

Decomposition:
- Shared package serial_add_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2
  - SLICE_W = 8
- One sub-module is natural: the existing CLA8 slice, instantiated once.
- FSM, operand registers and byte-select muxing stay in serial_add_ctrl.

Test Plan:
- Add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, carry_out=0, data_ready exactly 5 edges after start.
- Sub 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, overflow=0, carry_out=0.
- Add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry_out=1, overflow=0; sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, overflow=1, carry_out=1.
- Start, then re-pulse ctrl_start with different operands during RUN -> second request ignored, first result intact, single data_ready pulse.
- Reset asserted in the cycle after the 2nd RUN edge -> next cycle all outputs 0, busy=0, no data_ready; a new start afterwards completes correctly.
- With SERIAL_ADD_EARLY_DONE_EN, add 0x00000012 + 0x00000034 -> result 0x00000046, data_ready 3 edges after start; without the macro, same result in 5 edges.
